mbox_cyc_ctl: RTL and testbench
===============================

Name: mbox_cyc_ctl

Overview:
- Sits directly downstream of the EBOX memory-control logic.
- Consumes its per-cycle memory request and request type: MBOX_CYC_REQ, LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH and PAGE_ILL_ENTRY.
- Runs the EBOX-to-MBOX request/acknowledge/response handshake.
- Produces the EBOX memory-wait stall, the AR/ARX load strobes on returning data, page-fail status and a non-existent-memory (NXM) timeout.

Parameters:
- TIMEOUT, 64, cycles without ACK or response before NXM is declared. Legal range 2..255.
- CW, 8, width of the timeout counter. Must satisfy 2**CW > TIMEOUT.

Ports:
- clk  in  1  EBOX MCL clock.
- RESET_n  in  1  asynchronous active-low reset.
- MBOX_CYC_REQ  in  1  start a memory cycle this clock.
- LOAD_AR  in  1  request type: read into AR.
- LOAD_ARX  in  1  request type: read into ARX.
- VMA_PAUSE  in  1  read-pause-write (RPW) cycle.
- VMA_WRITE  in  1  request type: write.
- VMA_FETCH  in  1  instruction fetch.
- PAGE_ILL_ENTRY  in  1  page fail/illegal entry for this request.
- MBOX_ACK  in  1  MBOX accepted the request (one-clock pulse).
- MBOX_RESP  in  1  MBOX data-valid or write-complete (one-clock pulse per word).
- PF_CLR  in  1  microcode clears a held page fail.
- EBOX_REQ  out  1  request to MBOX.
- EBOX_RD  out  1  held read type.
- EBOX_WR  out  1  held write type.
- EBOX_RPW  out  1  held pause type.
- EBOX_FETCH  out  1  held fetch qualifier.
- MEM_WAIT  out  1  stall the EBOX clock.
- AR_LOAD  out  1  load AR from the MBOX data bus.
- ARX_LOAD  out  1  load ARX from the MBOX data bus.
- PAGE_FAIL  out  1  page fail held.
- NXM_ERR  out  1  one-clock timeout pulse.
- OVERRUN  out  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - Held type register and counter are cleared to 0.
  - Every output is 0, including the sticky OVERRUN.
  - Release is synchronous to the next clk edge.
- States: IDLE, REQ, RD_WAIT, WR_WAIT, RPW_HOLD, PF.
- Held type register:
  - Loaded with {LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH} on the clock a request is accepted.
  - EBOX_RD = held LOAD_AR | held LOAD_ARX.
  - EBOX_WR, EBOX_RPW, EBOX_FETCH drive from the held bits in every state except IDLE; they are 0 in IDLE.
- IDLE, MBOX_CYC_REQ=1:
  - With PAGE_ILL_ENTRY=1: go to PF. No MBOX request is made.
  - With PAGE_ILL_ENTRY=0: latch the type and go to REQ.
  - A request with no type bit set is a no-op and sets OVERRUN.
- REQ:
  - EBOX_REQ=1 until MBOX_ACK.
  - On ACK: go to RD_WAIT if the held read is set, otherwise WR_WAIT. The counter clears.
- RD_WAIT:
  - First MBOX_RESP: AR_LOAD=1 that same clock if held LOAD_AR, otherwise ARX_LOAD=1.
  - If both LOAD_AR and LOAD_ARX are held, the second RESP gives ARX_LOAD=1.
  - After the last word: go to RPW_HOLD if VMA_PAUSE is held, else IDLE.
  - The counter clears on each RESP.
- WR_WAIT: on MBOX_RESP go to IDLE.
- RPW_HOLD:
  - MEM_WAIT=0; the EBOX runs.
  - Next MBOX_CYC_REQ with VMA_WRITE=1: reload the type as write-only, go to REQ (write half).
  - MBOX_CYC_REQ with VMA_WRITE=0: set OVERRUN and go to IDLE; the request is dropped.
  - No timeout runs in RPW_HOLD.
- PF:
  - PAGE_FAIL=1 and MEM_WAIT=0.
  - Requests are ignored.
  - PF_CLR returns the state to IDLE on the next clock.
- MEM_WAIT = state in {REQ, RD_WAIT, WR_WAIT}, registered. It is also 1 combinationally in IDLE on the accepting clock when the request goes to REQ.
- MBOX_CYC_REQ while in REQ, RD_WAIT or WR_WAIT: sets OVERRUN; the current cycle is unaffected.
- Timeout:
  - The counter increments each clock in REQ, RD_WAIT and WR_WAIT.
  - When it reaches TIMEOUT: NXM_ERR=1 for one clock, state goes to IDLE, counter clears.
  - The counter saturates; it never wraps.
- ACK/RESP outside the states that consume them: ignored.
- ACK and RESP in the same clock while in REQ: the ACK is taken and the RESP is treated as the first RESP in the next state.
- AR_LOAD and ARX_LOAD are never both 1 in the same clock.

Test Plan:
- Single read: REQ(LOAD_AR), then ACK at +3 and RESP at +5.
  - Expect EBOX_REQ high for cycles 1–3.
  - MEM_WAIT high from the accept clock through the RESP clock.
  - AR_LOAD one pulse coincident with RESP; state back to IDLE.
- Double read: LOAD_AR+LOAD_ARX with RESPs at +4 and +6.
  - Expect AR_LOAD at +4 and ARX_LOAD at +6, never together.
- RPW: VMA_PAUSE+LOAD_AR+VMA_WRITE.
  - After RESP: MEM_WAIT=0 and EBOX_RPW=1.
  - A following REQ with VMA_WRITE=1 issues a write; its RESP returns to IDLE.
  - A following REQ with VMA_WRITE=0 sets OVERRUN.
- Page fail: REQ with PAGE_ILL_ENTRY=1.
  - Expect no EBOX_REQ and PAGE_FAIL=1 held.
  - Further REQs ignored until PF_CLR; PAGE_FAIL=0 one clock after PF_CLR.
- NXM with TIMEOUT=4: REQ with no ACK.
  - Expect NXM_ERR pulse 4 clocks into REQ, then IDLE.
  - Expect MEM_WAIT=0 the following clock.
- Reset mid-cycle: assert RESET_n=0 in RD_WAIT between edges.
  - All outputs 0 immediately (asynchronous).
  - After release, a new read completes normally.

Source files
------------

// File: rtl/mbox_cyc_ctl.sv
// EBOX-to-MBOX memory cycle controller: request/ack/response handshake,
// EBOX memory-wait stall, AR/ARX load strobes, page-fail hold and NXM timeout.
module mbox_cyc_ctl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 8
) (
    input  logic clk,
    input  logic RESET_n,
    input  logic MBOX_CYC_REQ,
    input  logic LOAD_AR,
    input  logic LOAD_ARX,
    input  logic VMA_PAUSE,
    input  logic VMA_WRITE,
    input  logic VMA_FETCH,
    input  logic PAGE_ILL_ENTRY,
    input  logic MBOX_ACK,
    input  logic MBOX_RESP,
    input  logic PF_CLR,
    output logic EBOX_REQ,
    output logic EBOX_RD,
    output logic EBOX_WR,
    output logic EBOX_RPW,
    output logic EBOX_FETCH,
    output logic MEM_WAIT,
    output logic AR_LOAD,
    output logic ARX_LOAD,
    output logic PAGE_FAIL,
    output logic NXM_ERR,
    output logic OVERRUN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_WAIT,
        S_WR_WAIT,
        S_RPW_HOLD,
        S_PF
    } state_e;

    // Held type bit positions: {LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH}
    localparam int unsigned T_AR  = 4;
    localparam int unsigned T_ARX = 3;
    localparam int unsigned T_PAU = 2;
    localparam int unsigned T_WR  = 1;
    localparam int unsigned T_FET = 0;

    state_e        state_q, state_d;
    logic [4:0]    type_q, type_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          word_q, word_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;

    logic       busy;
    logic       tmo;
    logic       accept;
    logic       resp_eff;
    logic       rd_resp;
    logic       ar_first;
    logic       last_word;
    logic [4:0] req_type;

    assign req_type  = {LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH};
    assign busy      = state_q inside {S_REQ, S_RD_WAIT, S_WR_WAIT};
    assign tmo       = busy && (cnt_q >= CW'(TIMEOUT));
    assign accept    = (state_q == S_IDLE) && MBOX_CYC_REQ && !PAGE_ILL_ENTRY && (|req_type);

    // A RESP that arrived together with the ACK is replayed as the first
    // response of the wait state that follows.
    assign resp_eff  = MBOX_RESP | pend_q;
    assign rd_resp   = (state_q == S_RD_WAIT) && resp_eff && !tmo;
    assign ar_first  = type_q[T_AR] && !word_q;
    assign last_word = !(type_q[T_AR] && type_q[T_ARX] && !word_q);

    assign EBOX_REQ   = (state_q == S_REQ);
    assign EBOX_RD    = type_q[T_AR] | type_q[T_ARX];
    assign EBOX_WR    = (state_q != S_IDLE) && type_q[T_WR];
    assign EBOX_RPW   = (state_q != S_IDLE) && type_q[T_PAU];
    assign EBOX_FETCH = (state_q != S_IDLE) && type_q[T_FET];
    // The accept term is input-driven, so it is held off while reset is asserted.
    assign MEM_WAIT   = busy | (accept & RESET_n);
    assign AR_LOAD    = rd_resp && ar_first;
    assign ARX_LOAD   = rd_resp && !ar_first;
    assign PAGE_FAIL  = (state_q == S_PF);
    assign NXM_ERR    = tmo;
    assign OVERRUN    = ovr_q;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        pend_d  = 1'b0;
        ovr_d   = ovr_q;

        if (busy) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
            if (MBOX_CYC_REQ) begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                word_d = 1'b0;
                if (MBOX_CYC_REQ) begin
                    if (PAGE_ILL_ENTRY) begin
                        state_d = S_PF;
                    end else if (|req_type) begin
                        type_d  = req_type;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (MBOX_ACK) begin
                    cnt_d   = '0;
                    word_d  = 1'b0;
                    pend_d  = MBOX_RESP;
                    state_d = (type_q[T_AR] | type_q[T_ARX]) ? S_RD_WAIT : S_WR_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (resp_eff) begin
                    cnt_d = '0;
                    if (last_word) begin
                        state_d = type_q[T_PAU] ? S_RPW_HOLD : S_IDLE;
                    end else begin
                        word_d = 1'b1;
                    end
                end
            end
            S_WR_WAIT: begin
                if (resp_eff) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_RPW_HOLD: begin
                if (MBOX_CYC_REQ) begin
                    if (VMA_WRITE) begin
                        type_d  = 5'b00010;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        ovr_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PF: begin
                if (PF_CLR) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            cnt_q   <= '0;
            word_q  <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_mbox_cyc_ctl.sv
// Table-driven bench for mbox_cyc_ctl with a scoreboard queue, plus a
// hand-written asynchronous-reset-in-RD_WAIT sequence.
module tb_mbox_cyc_ctl;

    localparam int unsigned TMO = 4;

    // Input vector bits
    localparam logic [9:0] I_REQ = 10'h200;
    localparam logic [9:0] I_AR  = 10'h100;
    localparam logic [9:0] I_ARX = 10'h080;
    localparam logic [9:0] I_PAU = 10'h040;
    localparam logic [9:0] I_WR  = 10'h020;
    localparam logic [9:0] I_FET = 10'h010;
    localparam logic [9:0] I_PIL = 10'h008;
    localparam logic [9:0] I_ACK = 10'h004;
    localparam logic [9:0] I_RSP = 10'h002;
    localparam logic [9:0] I_CLR = 10'h001;

    // Output vector bits
    localparam logic [10:0] O_REQ  = 11'h400;
    localparam logic [10:0] O_RD   = 11'h200;
    localparam logic [10:0] O_WR   = 11'h100;
    localparam logic [10:0] O_RPW  = 11'h080;
    localparam logic [10:0] O_FET  = 11'h040;
    localparam logic [10:0] O_MW   = 11'h020;
    localparam logic [10:0] O_ARL  = 11'h010;
    localparam logic [10:0] O_ARXL = 11'h008;
    localparam logic [10:0] O_PF   = 11'h004;
    localparam logic [10:0] O_NXM  = 11'h002;
    localparam logic [10:0] O_OVR  = 11'h001;
    localparam logic [10:0] ALL    = 11'h7FF;
    // EBOX_RD follows the held type even in IDLE, so it is stale there
    localparam logic [10:0] NRD    = ALL & ~O_RD;
    localparam logic [10:0] NHLD   = ALL & ~(O_RD | O_WR | O_RPW | O_FET);

    logic clk = 1'b0;
    logic RESET_n;
    logic MBOX_CYC_REQ, LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH;
    logic PAGE_ILL_ENTRY, MBOX_ACK, MBOX_RESP, PF_CLR;
    logic EBOX_REQ, EBOX_RD, EBOX_WR, EBOX_RPW, EBOX_FETCH, MEM_WAIT;
    logic AR_LOAD, ARX_LOAD, PAGE_FAIL, NXM_ERR, OVERRUN;
    logic [10:0] outs;

    always #5 clk = ~clk;

    mbox_cyc_ctl #(.TIMEOUT(TMO), .CW(8)) dut (
        .clk(clk), .RESET_n(RESET_n),
        .MBOX_CYC_REQ(MBOX_CYC_REQ), .LOAD_AR(LOAD_AR), .LOAD_ARX(LOAD_ARX),
        .VMA_PAUSE(VMA_PAUSE), .VMA_WRITE(VMA_WRITE), .VMA_FETCH(VMA_FETCH),
        .PAGE_ILL_ENTRY(PAGE_ILL_ENTRY), .MBOX_ACK(MBOX_ACK), .MBOX_RESP(MBOX_RESP),
        .PF_CLR(PF_CLR),
        .EBOX_REQ(EBOX_REQ), .EBOX_RD(EBOX_RD), .EBOX_WR(EBOX_WR), .EBOX_RPW(EBOX_RPW),
        .EBOX_FETCH(EBOX_FETCH), .MEM_WAIT(MEM_WAIT), .AR_LOAD(AR_LOAD),
        .ARX_LOAD(ARX_LOAD), .PAGE_FAIL(PAGE_FAIL), .NXM_ERR(NXM_ERR), .OVERRUN(OVERRUN)
    );

    assign outs = {EBOX_REQ, EBOX_RD, EBOX_WR, EBOX_RPW, EBOX_FETCH, MEM_WAIT,
                   AR_LOAD, ARX_LOAD, PAGE_FAIL, NXM_ERR, OVERRUN};

    typedef struct {
        logic        rst;
        logic [9:0]  in;
        logic [10:0] exp;
        logic [10:0] msk;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        logic [10:0] msk;
        int          idx;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(input logic rst, input logic [9:0] in,
                                input logic [10:0] exp, input logic [10:0] msk);
        vec_t v;
        v.rst = rst;
        v.in  = in;
        v.exp = exp;
        v.msk = msk;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic [9:0] in);
        RESET_n = !rst;
        {MBOX_CYC_REQ, LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH,
         PAGE_ILL_ENTRY, MBOX_ACK, MBOX_RESP, PF_CLR} = in;
    endtask

    task automatic push_exp(input logic [10:0] exp, input logic [10:0] msk, input int idx);
        sb_t e;
        e.exp = exp;
        e.msk = msk;
        e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic check_out(input string nm);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, outputs=%b", nm, outs);
        end else begin
            e = sb.pop_front();
            if ((outs & e.msk) !== (e.exp & e.msk)) begin
                n_fail++;
                $display("FAIL %s %0d: outputs=%b required=%b mask=%b",
                         nm, e.idx, outs, e.exp, e.msk);
            end
        end
    endtask

    task automatic apply(input logic rst, input logic [9:0] in, input logic [10:0] exp,
                         input logic [10:0] msk, input string nm, input int idx);
        @(negedge clk);
        drive(rst, in);
        push_exp(exp, msk, idx);
        #1 check_out(nm);
    endtask

    initial begin
        bit seen;
        drive(1'b1, '0);

        // Reset
        add(1, '0, '0, ALL);
        // Single read: ACK at +3, RESP at +5
        add(0, I_REQ | I_AR, O_MW, ALL);
        add(0, '0, O_REQ | O_RD | O_MW, ALL);
        add(0, '0, O_REQ | O_RD | O_MW, ALL);
        add(0, I_ACK, O_REQ | O_RD | O_MW, ALL);
        add(0, '0, O_RD | O_MW, ALL);
        add(0, I_RSP, O_RD | O_MW | O_ARL, ALL);
        add(0, '0, '0, NRD);
        // Double read with fetch: RESPs at +4 and +6
        add(0, I_REQ | I_AR | I_ARX | I_FET, O_MW, NRD);
        add(0, '0, O_REQ | O_RD | O_FET | O_MW, ALL);
        add(0, I_ACK, O_REQ | O_RD | O_FET | O_MW, ALL);
        add(0, '0, O_RD | O_FET | O_MW, ALL);
        add(0, I_RSP, O_RD | O_FET | O_MW | O_ARL, ALL);
        add(0, '0, O_RD | O_FET | O_MW, ALL);
        add(0, I_RSP, O_RD | O_FET | O_MW | O_ARXL, ALL);
        add(0, '0, '0, NRD);
        // RPW: read half, long hold with no timeout, then write half
        add(0, I_REQ | I_AR | I_PAU | I_WR, O_MW, NRD);
        add(0, I_ACK, O_REQ | O_RD | O_WR | O_RPW | O_MW, ALL);
        add(0, '0, O_RD | O_WR | O_RPW | O_MW, ALL);
        add(0, I_RSP, O_RD | O_WR | O_RPW | O_MW | O_ARL, ALL);
        for (int unsigned k = 0; k < 6; k++) add(0, '0, O_RD | O_WR | O_RPW, ALL);
        add(0, I_REQ | I_WR, O_RD | O_WR | O_RPW, ALL);
        add(0, '0, O_REQ | O_WR | O_MW, ALL);
        add(0, I_ACK, O_REQ | O_WR | O_MW, ALL);
        add(0, I_RSP, O_WR | O_MW, ALL);
        add(0, '0, '0, ALL);
        // Stray ACK/RESP in IDLE
        add(0, I_ACK | I_RSP, '0, ALL);
        add(0, '0, '0, ALL);
        // Page fail
        add(0, I_REQ | I_AR | I_PIL, '0, ALL);
        add(0, '0, O_PF, NHLD);
        add(0, I_REQ | I_AR, O_PF, NHLD);
        add(0, I_CLR, O_PF, NHLD);
        add(0, '0, '0, ALL);
        // NXM: no ACK, pulse after TMO clocks in REQ
        add(0, I_REQ | I_ARX, O_MW, ALL);
        for (int unsigned k = 0; k < TMO; k++) add(0, '0, O_REQ | O_RD | O_MW, ALL);
        add(0, '0, O_REQ | O_RD | O_MW | O_NXM, ALL);
        add(0, '0, '0, NRD);
        add(0, '0, '0, NRD);
        // ACK on the last clock before timeout still completes
        add(0, I_REQ | I_AR, O_MW, NRD);
        for (int unsigned k = 0; k < TMO - 1; k++) add(0, '0, O_REQ | O_RD | O_MW, ALL);
        add(0, I_ACK, O_REQ | O_RD | O_MW, ALL);
        add(0, I_RSP, O_RD | O_MW | O_ARL, ALL);
        add(0, '0, '0, NRD);
        // RPW followed by a non-write request: dropped, OVERRUN
        add(0, I_REQ | I_AR | I_PAU, O_MW, NRD);
        add(0, I_ACK, O_REQ | O_RD | O_RPW | O_MW, ALL);
        add(0, I_RSP, O_RD | O_RPW | O_MW | O_ARL, ALL);
        add(0, I_REQ | I_AR, O_RD | O_RPW, ALL);
        add(0, '0, O_OVR, NRD);
        add(1, I_REQ | I_AR, '0, ALL);
        // Request with no type bit
        add(0, I_REQ, '0, ALL);
        add(0, '0, O_OVR, ALL);
        add(1, '0, '0, ALL);
        // Request while busy
        add(0, I_REQ | I_AR, O_MW, ALL);
        add(0, I_REQ | I_AR, O_REQ | O_RD | O_MW, ALL);
        add(0, I_ACK, O_REQ | O_RD | O_MW | O_OVR, ALL);
        add(0, I_RSP, O_RD | O_MW | O_ARL | O_OVR, ALL);
        add(0, '0, O_OVR, NRD);
        add(1, '0, '0, ALL);
        // ACK and RESP together: read, then write
        add(0, I_REQ | I_AR, O_MW, ALL);
        add(0, I_ACK | I_RSP, O_REQ | O_RD | O_MW, ALL);
        add(0, '0, O_RD | O_MW | O_ARL, ALL);
        add(0, '0, '0, NRD);
        add(0, I_REQ | I_WR, O_MW, NRD);
        add(0, I_ACK | I_RSP, O_REQ | O_WR | O_MW, ALL);
        add(0, '0, O_WR | O_MW, ALL);
        add(0, '0, '0, ALL);

        foreach (vecs[i]) apply(vecs[i].rst, vecs[i].in, vecs[i].exp, vecs[i].msk, "vec", i);

        // Asynchronous reset while in RD_WAIT
        apply(0, I_REQ | I_AR, O_MW, NRD, "arst_req", 0);
        apply(0, I_ACK, O_REQ | O_RD | O_MW, ALL, "arst_ack", 0);
        apply(0, '0, O_RD | O_MW, ALL, "arst_rdwait", 0);
        #2 RESET_n = 1'b0;
        push_exp('0, ALL, 0);
        #1 check_out("arst_now");
        apply(1, '0, '0, ALL, "arst_hold", 0);
        apply(0, I_REQ | I_AR, O_MW, ALL, "post_req", 0);
        apply(0, I_ACK, O_REQ | O_RD | O_MW, ALL, "post_ack", 0);
        seen = 1'b0;
        for (int unsigned k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            drive(1'b0, I_RSP);
            #1 seen = AR_LOAD;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL post_arload: AR_LOAD=0 within 8 cycles, required 1");
        end
        apply(0, '0, '0, NRD, "post_idle", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
